// File: rtl/hit_judge_pkg.sv
// Shared game definitions for the piano-tile pipeline (lookup, lane ROM, judge).
package hit_judge_pkg;

    localparam int unsigned TOTAL_TILES = 44;
    localparam int unsigned LOOKAHEAD   = 2;
    localparam int unsigned LAST_BEAT   = 96;

    localparam int unsigned BEAT_W  = 7;
    localparam int unsigned TILE_W  = 6;
    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned SCORE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FAIL  = 2'd2,
        ST_CLEAR = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_LATE  = 2'd1,
        FC_WRONG = 2'd2,
        FC_MULTI = 2'd3
    } fail_code_e;

    typedef struct packed {
        logic              valid;
        logic              multi;
        logic [LANE_W-1:0] lane;
    } key_dec_t;

    // Saturating score increment.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/hit_judge_key_decode.sv
// Combinational key decoder: lane pulses -> {valid, multi, lane}.
module hit_judge_key_decode
    import hit_judge_pkg::*;
(
    input  logic [LANES-1:0] key_lane,
    output key_dec_t         key_dec_c
);

    // Any bit set, more than one bit set, and the encoded lane of a single press.
    always_comb begin
        key_dec_c       = '0;
        key_dec_c.valid = |key_lane;
        key_dec_c.multi = |(key_lane & (key_lane - LANES'(1)));
        case (key_lane)
            4'b0001: key_dec_c.lane = 2'd0;
            4'b0010: key_dec_c.lane = 2'd1;
            4'b0100: key_dec_c.lane = 2'd2;
            4'b1000: key_dec_c.lane = 2'd3;
            default: key_dec_c.lane = 2'd0;
        endcase
    end

endmodule

// File: rtl/hit_judge.sv
// Piano-tile game judge: hit counter, score/best score and game state FSM.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned TOTAL_TILES_P = TOTAL_TILES,
    parameter int unsigned LOOKAHEAD_P   = LOOKAHEAD,
    parameter int unsigned LAST_BEAT_P   = LAST_BEAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               beat_tick,
    input  logic [BEAT_W-1:0]  beat_cnt,
    input  logic [TILE_W-1:0]  h_req,
    input  logic [LANES-1:0]   key_lane,
    input  logic [LANE_W-1:0]  tile_lane,
    output logic [TILE_W-1:0]  tile_idx,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score,
    output logic [1:0]         state,
    output logic [1:0]         fail_code
);

    localparam logic [TILE_W-1:0] TOTAL_V = TILE_W'(TOTAL_TILES_P);
    localparam logic [BEAT_W-1:0] LAST_V  = BEAT_W'(LAST_BEAT_P);
    localparam logic [TILE_W:0]   AHEAD_V = (TILE_W+1)'(LOOKAHEAD_P);

    game_state_e        state_q, state_d;
    fail_code_e         fcode_q, fcode_d;
    logic [TILE_W-1:0]  idx_q, idx_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;

    key_dec_t           kd;
    logic [TILE_W-1:0]  idx_post;
    logic [SCORE_W-1:0] score_post;
    logic [TILE_W:0]    hit_limit;

    hit_judge_key_decode u_key_decode (
        .key_lane  (key_lane),
        .key_dec_c (kd)
    );

    assign hit_limit = (TILE_W+1)'(h_req) + AHEAD_V;

    // Next-state: key resolves first, then clear detection, then the beat check.
    always_comb begin
        state_d    = state_q;
        fcode_d    = fcode_q;
        idx_d      = idx_q;
        score_d    = score_q;
        best_d     = best_q;
        idx_post   = idx_q;
        score_post = score_q;

        case (state_q)
            ST_PLAY: begin
                if (start) begin
                    idx_d   = '0;
                    score_d = '0;
                    fcode_d = FC_NONE;
                end else if (kd.valid && kd.multi) begin
                    state_d = ST_FAIL;
                    fcode_d = FC_MULTI;
                    best_d  = (score_q > best_q) ? score_q : best_q;
                end else if (kd.valid && (kd.lane != tile_lane)) begin
                    state_d = ST_FAIL;
                    fcode_d = FC_WRONG;
                    best_d  = (score_q > best_q) ? score_q : best_q;
                end else begin
                    // A correct key beyond the look-ahead window is silently dropped.
                    if (kd.valid && ((TILE_W+1)'(idx_q) < hit_limit)) begin
                        idx_post   = idx_q + TILE_W'(1);
                        score_post = score_inc(score_q);
                    end
                    idx_d   = idx_post;
                    score_d = score_post;
                    if (idx_post == TOTAL_V) begin
                        state_d = ST_CLEAR;
                        best_d  = (score_post > best_q) ? score_post : best_q;
                    end else if (beat_tick && (beat_cnt <= LAST_V) && (idx_post < h_req)) begin
                        state_d = ST_FAIL;
                        fcode_d = FC_LATE;
                        best_d  = (score_post > best_q) ? score_post : best_q;
                    end
                end
            end
            default: begin
                // IDLE, FAIL and CLEAR all wait for start; best score is retained.
                if (start) begin
                    state_d = ST_PLAY;
                    idx_d   = '0;
                    score_d = '0;
                    fcode_d = FC_NONE;
                end
            end
        endcase
    end

    // Game registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcode_q <= FC_NONE;
            idx_q   <= '0;
            score_q <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            fcode_q <= fcode_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            best_q  <= best_d;
        end
    end

    assign state      = state_q;
    assign fail_code  = fcode_q;
    assign tile_idx   = idx_q;
    assign score      = score_q;
    assign best_score = best_q;

endmodule
